// File: rtl/tx_interface.sv
// rtl/tx_interface.sv - converts an ALU result to three ASCII decimal digits plus an optional terminator for a UART transmitter
module tx_interface #(
    parameter int         DBIT     = 8,
    parameter logic [7:0] EOL_CHAR = 8'd10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [DBIT-1:0] result,
    input  logic            tx_done_tick,
    output logic [7:0]      din,
    output logic            tx_start,
    output logic            rd,
    output logic            busy
);
    typedef enum logic [2:0] {IDLE, CONV, LOAD, WAIT, ACK, RELEASE} state_t;

    localparam logic [1:0]      LAST_IDX = (EOL_CHAR == 8'd0) ? 2'd2 : 2'd3;
    localparam logic [DBIT-1:0] C100     = DBIT'(100);
    localparam logic [DBIT-1:0] C10      = DBIT'(10);

    state_t          r_state;
    logic [DBIT-1:0] r_rem;
    logic [1:0]      r_hund;
    logic [3:0]      r_tens;
    logic [1:0]      r_idx;
    logic [7:0]      r_din;
    logic            r_tx_start;
    logic            r_rd;
    logic            r_busy;

    logic [1:0]      w_next_idx;
    logic [7:0]      w_next_char;

    assign w_next_idx = r_idx + 2'd1;

    // Character for the byte that follows the one currently in flight.
    always_comb begin
        w_next_char = EOL_CHAR;
        case (w_next_idx)
            2'd1:    w_next_char = 8'd48 + {4'd0, r_tens};
            2'd2:    w_next_char = 8'd48 + r_rem[7:0];
            default: w_next_char = EOL_CHAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_hund     <= '0;
            r_tens     <= '0;
            r_idx      <= '0;
            r_din      <= '0;
            r_tx_start <= 1'b0;
            r_rd       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem   <= result;
                        r_hund  <= '0;
                        r_tens  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    if (r_rem >= C100) begin
                        r_rem  <= r_rem - C100;
                        r_hund <= r_hund + 2'd1;
                    end else if (r_rem >= C10) begin
                        r_rem  <= r_rem - C10;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_idx      <= 2'd0;
                        r_din      <= 8'd48 + {6'd0, r_hund};
                        r_tx_start <= 1'b1;
                        r_state    <= LOAD;
                    end
                end
                LOAD: begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        if (r_idx == LAST_IDX) begin
                            r_rd    <= 1'b1;
                            r_state <= ACK;
                        end else begin
                            r_idx      <= w_next_idx;
                            r_din      <= w_next_char;
                            r_tx_start <= 1'b1;
                            r_state    <= LOAD;
                        end
                    end
                end
                ACK: begin
                    r_rd    <= 1'b0;
                    r_state <= RELEASE;
                end
                RELEASE: begin
                    // Hold off until the request level drops so one request sends once.
                    if (!start) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign din      = r_din;
    assign tx_start = r_tx_start;
    assign rd       = r_rd;
    assign busy     = r_busy;
endmodule

// File: tb/tb_tx_interface.sv
// tb/tb_tx_interface.sv - directed bench for tx_interface (terminator and no-terminator builds)
module tb_tx_interface;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tx_done_tick = 1'b0;
    logic [7:0] result = 8'd0;
    logic [7:0] din0, din1;
    logic       tx_start0, tx_start1, rd0, rd1, busy0, busy1;

    int total = 0;
    int bad = 0;

    logic [31:0] got0, got1;
    int n0, n1, rd0n, rd1n, n1_at_rd1, conv, overlap, timeout;

    always #5 clk = ~clk;

    tx_interface #(.DBIT(8), .EOL_CHAR(8'd10)) dut0 (
        .clk(clk), .reset(reset), .start(start), .result(result), .tx_done_tick(tx_done_tick),
        .din(din0), .tx_start(tx_start0), .rd(rd0), .busy(busy0)
    );

    tx_interface #(.DBIT(8), .EOL_CHAR(8'd0)) dut1 (
        .clk(clk), .reset(reset), .start(start), .result(result), .tx_done_tick(tx_done_tick),
        .din(din1), .tx_start(tx_start1), .rd(rd1), .busy(busy1)
    );

    // Drives one request, answers each tx_start of dut0 with a tick 5 cycles later, records bytes.
    task automatic collect(input logic [7:0] res);
        int   cd;
        int   post;
        logic prev_ts;
        logic prev_rd;
        got0 = '0; got1 = '0; n0 = 0; n1 = 0; rd0n = 0; rd1n = 0; n1_at_rd1 = -1;
        conv = -1; overlap = 0; timeout = 1; cd = -1; post = 0; prev_ts = 0; prev_rd = 0;
        @(negedge clk);
        result = res;
        start = 1'b1;
        tx_done_tick = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            tx_done_tick = 1'b0;
            if (cyc == 1) result = ~res;
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done_tick = 1'b1;
            end
            if (tx_start0) begin
                got0 = {got0[23:0], din0};
                n0++;
                cd = 5;
                if (conv < 0) conv = cyc - 1;
            end
            if (tx_start1) begin
                got1 = {got1[23:0], din1};
                n1++;
            end
            if (rd0) rd0n++;
            if (rd1) begin
                rd1n++;
                n1_at_rd1 = n1;
            end
            if ((tx_start0 && rd0) || (tx_start1 && rd1) || (tx_start0 && prev_ts) || (rd0 && prev_rd))
                overlap++;
            prev_ts = tx_start0;
            prev_rd = rd0;
            if (rd0n > 0) post++;
            if (post == 4) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; tx_done_tick = 1'b1; result = 8'd99;
        @(negedge clk);
        @(negedge clk);
        total++; if (din0 !== 8'd0) begin bad++; $display("FAIL reset_din got=%0d want=0", din0); end
        total++; if ({tx_start0, rd0, busy0} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {tx_start0, rd0, busy0}); end
        total++; if ({din1, tx_start1, rd1, busy1} !== 11'd0) begin bad++; $display("FAIL reset_noeol got=%h want=0", {din1, tx_start1, rd1, busy1}); end
        reset = 1'b0; start = 1'b0; tx_done_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        collect(8'd0);
        total++; if (timeout !== 0) begin bad++; $display("FAIL zero_timeout got=%0d want=0", timeout); end
        total++; if (n0 !== 4 || got0 !== 32'h3030_300A) begin bad++; $display("FAIL zero_bytes got=%0d/%h want=4/3030300a", n0, got0); end
        total++; if (rd0n !== 1) begin bad++; $display("FAIL zero_rd got=%0d want=1", rd0n); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL zero_overlap got=%0d want=0", overlap); end
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL zero_busy_release got=%b want=1", busy0); end
        drop_start();
        total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL zero_busy_idle got=%b want=0", busy0); end
    endtask

    task automatic test_255();
        collect(8'd255);
        total++; if (n0 !== 4 || got0 !== 32'h3235_350A) begin bad++; $display("FAIL r255_bytes got=%0d/%h want=4/3235350a", n0, got0); end
        total++; if (conv > 8 || conv < 1) begin bad++; $display("FAIL r255_conv got=%0d want<=8", conv); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL r255_overlap got=%0d want=0", overlap); end
        drop_start();
    endtask

    task automatic test_199_noeol();
        collect(8'd199);
        total++; if (n0 !== 4 || got0 !== 32'h3139_390A) begin bad++; $display("FAIL r199_bytes got=%0d/%h want=4/3139390a", n0, got0); end
        total++; if (conv > 12 || conv < 1) begin bad++; $display("FAIL r199_conv got=%0d want<=12", conv); end
        total++; if (n1 !== 3 || got1 !== 32'h0031_3939) begin bad++; $display("FAIL noeol_bytes got=%0d/%h want=3/313939", n1, got1); end
        total++; if (rd1n !== 1 || n1_at_rd1 !== 3) begin bad++; $display("FAIL noeol_rd got=%0d@%0d want=1@3", rd1n, n1_at_rd1); end
        drop_start();
        total++; if ({busy0, busy1} !== 2'b00) begin bad++; $display("FAIL r199_busy got=%b want=00", {busy0, busy1}); end
    endtask

    task automatic test_withheld();
        logic [7:0] d;
        int seen, changes, ts, rdc;
        seen = 0; changes = 0; ts = 0; rdc = 0; d = 8'hFF;
        @(negedge clk);
        result = 8'd5; start = 1'b1;
        for (int i = 0; i < 30 && seen == 0; i++) begin
            @(negedge clk);
            if (tx_start0) begin seen = 1; d = din0; end
        end
        total++; if (seen !== 1 || d !== 8'h30) begin bad++; $display("FAIL hold_first got=%0d/%h want=1/30", seen, d); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (din0 !== d) changes++;
            if (tx_start0) ts++;
            if (rd0) rdc++;
        end
        total++; if (changes !== 0) begin bad++; $display("FAIL hold_din got=%0d want=0", changes); end
        total++; if (ts !== 0 || rdc !== 0) begin bad++; $display("FAIL hold_pulses got=%0d/%0d want=0/0", ts, rdc); end
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b want=1", busy0); end
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ts, cd;
        logic [7:0] d;
        ts = 0; cd = -1; d = 8'h00;
        @(negedge clk);
        result = 8'd123; start = 1'b1;
        for (int i = 0; i < 200 && ts < 2; i++) begin
            @(negedge clk);
            tx_done_tick = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) tx_done_tick = 1'b1;
            end
            if (tx_start0) begin ts++; d = din0; cd = 5; end
        end
        total++; if (ts !== 2 || d !== 8'h32) begin bad++; $display("FAIL mid_byte2 got=%0d/%h want=2/32", ts, d); end
        tx_done_tick = 1'b0;
        @(negedge clk);
        reset = 1'b1; tx_done_tick = 1'b1; start = 1'b1;
        @(negedge clk);
        total++; if ({din0, tx_start0, rd0, busy0} !== 11'd0) begin bad++; $display("FAIL mid_reset got=%h want=0", {din0, tx_start0, rd0, busy0}); end
        reset = 1'b0; tx_done_tick = 1'b0; start = 1'b0;
        @(negedge clk);
        collect(8'd42);
        total++; if (n0 !== 4 || got0 !== 32'h3034_320A) begin bad++; $display("FAIL r42_bytes got=%0d/%h want=4/3034320a", n0, got0); end
    endtask

    task automatic test_back_to_back();
        int ts, rdc;
        ts = 0; rdc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_start0) ts++;
            if (rd0) rdc++;
        end
        total++; if (ts !== 0 || rdc !== 0) begin bad++; $display("FAIL held_start got=%0d/%0d want=0/0", ts, rdc); end
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL held_busy got=%b want=1", busy0); end
        drop_start();
        collect(8'd7);
        total++; if (n0 !== 4 || got0 !== 32'h3030_370A) begin bad++; $display("FAIL r7_bytes got=%0d/%h want=4/3030370a", n0, got0); end
        total++; if (rd0n !== 1 || overlap !== 0) begin bad++; $display("FAIL r7_rd got=%0d/%0d want=1/0", rd0n, overlap); end
        drop_start();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_255();
        test_199_noeol();
        test_withheld();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tx_interface.md
TX_INTERFACE -- requirements
Module: tx_interface

Interface
REQ-001 Parameter DBIT, default 8, width of the result operand and of the UART data byte.
REQ-002 Parameter EOL_CHAR, default 8'd10, terminator byte sent after the digits; 0 disables the terminator.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  level request from the rx side (its rx_empty): operands and opcode are valid and the result is ready.
REQ-006 result  input  DBIT  unsigned ALU result to transmit.
REQ-007 tx_done_tick  input  1  one-cycle pulse from the UART transmitter: the current byte has been sent.
REQ-008 din  output  8  ASCII byte presented to the UART transmitter.
REQ-009 tx_start  output  1  one-cycle pulse that launches transmission of din.
REQ-010 rd  output  1  one-cycle acknowledge to the rx side; clears its rx_empty.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM shall have exactly these states: IDLE, CONV, LOAD, WAIT, ACK, RELEASE.
REQ-013 IDLE: on start=1, latch result into rem, clear hund and tens, and go to CONV; tx_done_tick is ignored.
REQ-014 CONV, one step per cycle: if rem>=100, rem-=100 and hund++; else if rem>=10, rem-=10 and tens++; else go to LOAD with char index 0.
REQ-015 CONV latency shall be at most 12 cycles for any 8-bit result; rem, hund and tens shall never overflow their widths (8, 2 and 4 bits).
REQ-016 Char sequence: index 0 = 48+hund, 1 = 48+tens, 2 = 48+rem, 3 = EOL_CHAR (skipped when EOL_CHAR=0).
REQ-017 Leading zeros shall always be sent; exactly three digit bytes per result.
REQ-018 LOAD: drive din with the selected char, assert tx_start for exactly this one cycle, and go to WAIT.
REQ-019 din shall remain stable from LOAD until tx_done_tick is sampled in WAIT.
REQ-020 WAIT: on tx_done_tick, increment the index and go to LOAD if chars remain, else go to ACK; with no tick, remain in WAIT indefinitely.
REQ-021 ACK: assert rd for exactly one cycle and go to RELEASE.
REQ-022 RELEASE: remain until start=0, then go to IDLE, so one request produces exactly one transmission.
REQ-023 tx_start and rd shall never be high in the same cycle; each shall be high for at most one consecutive cycle.
REQ-024 A change of result after latching in IDLE shall not affect the transmitted bytes.

Reset
REQ-025 reset=1 at a clock edge shall force IDLE and clear din=0, tx_start=0, rd=0, busy=0, rem=0, hund=0, tens=0 and index=0.
REQ-026 Reset shall take priority over start and tx_done_tick in the same cycle.
REQ-027 Reset mid-operation shall abandon the current result; the next start restarts from the hundreds digit.

Verification
REQ-028 result=0, start held high, tx_done_tick 5 cycles after each tx_start -> din sequence 48,48,48,10; then one rd pulse; busy=0 after start drops.
REQ-029 result=255 -> din sequence 50,53,53,10; CONV completes in 8 cycles or fewer.
REQ-030 result=199 -> din sequence 49,57,57,10; CONV takes at most 12 cycles; EOL_CHAR=0 build -> 49,57,57 only, with rd after the third byte.
REQ-031 tx_done_tick withheld 100 cycles in WAIT -> din held at first char, no second tx_start, rd=0.
REQ-032 reset asserted during WAIT of byte 2 -> next cycle all outputs 0, state IDLE; new start with result=42 -> 48,52,50,10.
REQ-033 start held high 50 cycles after rd -> no further tx_start; start low then high with result=7 -> 48,48,55,10.
